ssm_step_seq_fp16: RTL

SSM_STEP_SEQ_FP16 -- requirements
Module: ssm_step_seq_fp16

---
 rtl/ssm_step_seq_fp16_pkg.sv | 24 ++
 rtl/fp16_add.sv | 65 ++++++
 rtl/fp16_mul.sv | 53 +++++
 rtl/ssm_row_fp16.sv | 84 ++++++++
 rtl/ssm_step_seq_fp16.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/ssm_step_seq_fp16_pkg.sv
// Shared types and constants for the FP16 selective-state-space step sequencer.
// Holds the FSM encoding, row datapath phases and the row latency formula.
package ssm_step_seq_fp16_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_DTX, S_ELEM, S_RES, S_OUT
   } state_e;

   typedef enum logic [2:0] {
      PH_DTX, PH_M1, PH_A1, PH_M2, PH_A2, PH_RM, PH_RA
   } phase_e;

   localparam logic [15:0] FP16_ZERO = 16'h0000;
   localparam logic [15:0] FP16_ONE  = 16'h3C00;

   function automatic int row_lat(int n, int m_lat, int a_lat, logic d_en);
      return m_lat + n * (2 * m_lat + 2 * a_lat) + (d_en ? m_lat + a_lat : 0);
   endfunction

   function automatic logic is_mul(phase_e ph);
      return ph inside {PH_DTX, PH_M1, PH_M2, PH_RM};
   endfunction

endpackage

// File: rtl/fp16_add.sv
// FP16 adder, round-to-nearest-even, subnormals flushed to zero.
// Result appears LAT-1 registers after the operands (LAT cycles incl. launch).
module fp16_add #(
   parameter int LAT = 11
) (
   input  logic        clk,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] s_o
);

   logic [15:0]       x, y, r;
   logic [4:0]        d;
   logic [13:0]       mx, my0, my, m;
   logic [14:0]       s;
   logic [11:0]       rnd;
   logic signed [7:0] e;
   int                msb;

   always_comb begin
      if (a[14:0] >= b[14:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      d   = x[14:10] - y[14:10];
      mx  = (x[14:10] != 5'd0) ? {1'b1, x[9:0], 3'b0} : 14'd0;
      my0 = (y[14:10] != 5'd0) ? {1'b1, y[9:0], 3'b0} : 14'd0;
      // shifted-out bits collapse into a sticky lsb
      my  = (my0 >> d) | 14'(|(my0 ^ ((my0 >> d) << d)));
      s   = (x[15] == y[15]) ? {1'b0, mx} + {1'b0, my}
                             : {1'b0, mx} - {1'b0, my};
      e   = $signed({3'b0, x[14:10]});
      msb = 0;
      for (int i = 0; i < 14; i++) if (s[i]) msb = i;
      if (s[14]) begin
         m = s[14:1] | {13'b0, s[0]};
         e = e + 8'sd1;
      end else begin
         m = s[13:0] << (13 - msb);
         e = e - 8'(13 - msb);
      end
      rnd = {1'b0, m[13:3]} + 12'(m[2] & ((|m[1:0]) | m[3]));
      if (rnd[11]) e = e + 8'sd1;
      r = {x[15], e[4:0], rnd[11] ? rnd[10:1] : rnd[9:0]};
      if (s == 15'd0 || e <= 0)
         r = 16'h0000;
      else if (e >= 31)
         r = {x[15], 5'h1f, 10'h0};
   end

   if (LAT > 1) begin : g_pipe
      logic [15:0] q [LAT-1];
      always_ff @(posedge clk) begin
         q[0] <= r;
         for (int i = 1; i < LAT - 1; i++) q[i] <= q[i-1];
      end
      assign s_o = q[LAT-2];
   end else begin : g_comb
      assign s_o = r;
   end

endmodule

// File: rtl/fp16_mul.sv
// FP16 multiplier, round-to-nearest-even, subnormals flushed to zero.
// Result appears LAT-1 registers after the operands (LAT cycles incl. launch).
module fp16_mul #(
   parameter int LAT = 6
) (
   input  logic        clk,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] p
);

   logic [15:0]       r;
   logic [21:0]       prod;
   logic [10:0]       man;
   logic [11:0]       rnd;
   logic signed [7:0] e;
   logic              g;
   logic              st;

   always_comb begin
      prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      e = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15;
      if (prod[21]) begin
         man = prod[21:11];
         g   = prod[10];
         st  = |prod[9:0];
         e   = e + 8'sd1;
      end else begin
         man = prod[20:10];
         g   = prod[9];
         st  = |prod[8:0];
      end
      rnd = {1'b0, man} + 12'(g & (st | man[0]));
      if (rnd[11]) e = e + 8'sd1;
      r = {a[15] ^ b[15], e[4:0], rnd[11] ? rnd[10:1] : rnd[9:0]};
      if (a[14:10] == 5'd0 || b[14:10] == 5'd0 || e <= 0)
         r = {a[15] ^ b[15], 15'h0};
      else if (e >= 31)
         r = {a[15] ^ b[15], 5'h1f, 10'h0};
   end

   if (LAT > 1) begin : g_pipe
      logic [15:0] q [LAT-1];
      always_ff @(posedge clk) begin
         q[0] <= r;
         for (int i = 1; i < LAT - 1; i++) q[i] <= q[i-1];
      end
      assign p = q[LAT-2];
   end else begin : g_comb
      assign p = r;
   end

endmodule

// File: rtl/ssm_row_fp16.sv
// One-row datapath: a multiplier pair and one adder, operands steered by phase.
// Intermediate results are latched on cap, the last cycle of each phase.
module ssm_row_fp16
   import ssm_step_seq_fp16_pkg::*;
#(
   parameter int DW    = 16,
   parameter int M_LAT = 6,
   parameter int A_LAT = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  phase_e        ph,
   input  logic          cap,
   input  logic          h_zero,
   input  logic [DW-1:0] dt,
   input  logic [DW-1:0] da,
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   input  logic [DW-1:0] d,
   input  logic [DW-1:0] hp,
   output logic [DW-1:0] sum
);

   logic [DW-1:0] dtx, p0, p1, hn, acc;
   logic [DW-1:0] m0a, m0b, m1a, m1b, aa, ab, m0, m1;

   always_comb begin
      m0a = dt;
      m0b = x;
      m1a = dtx;
      m1b = b;
      aa  = acc;
      ab  = p0;
      unique case (ph)
         PH_M1: begin
            m0a = da;
            m0b = h_zero ? FP16_ZERO : hp;
         end
         PH_M2: begin
            m0a = hn;
            m0b = c;
         end
         PH_RM: begin
            m0a = d;
            m0b = x;
         end
         PH_A1: begin
            aa = p0;
            ab = p1;
         end
         default: ;
      endcase
   end

   fp16_mul #(.LAT(M_LAT)) u_m0 (.clk(clk), .a(m0a), .b(m0b), .p(m0));
   fp16_mul #(.LAT(M_LAT)) u_m1 (.clk(clk), .a(m1a), .b(m1b), .p(m1));
   fp16_add #(.LAT(A_LAT)) u_a  (.clk(clk), .a(aa), .b(ab), .s_o(sum));

   always_ff @(posedge clk) begin
      if (rst) begin
         dtx <= '0;
         p0  <= '0;
         p1  <= '0;
         hn  <= '0;
         acc <= '0;
      end else if (cap) begin
         unique case (ph)
            PH_DTX: begin
               dtx <= m0;
               acc <= FP16_ZERO;
            end
            PH_M1: begin
               p0 <= m0;
               p1 <= m1;
            end
            PH_A1:        hn  <= sum;
            PH_M2, PH_RM: p0  <= m0;
            default:      acc <= sum;
         endcase
      end
   end

endmodule

// File: rtl/ssm_step_seq_fp16.sv
// Sequential FP16 SSM step: h_next = dA*h + dt*x*B, y = sum(h_next*C) + D*x.
// Rows run h-outer/p-inner through one shared row datapath; outputs held to handshake.
module ssm_step_seq_fp16
   import ssm_step_seq_fp16_pkg::*;
#(
   parameter int H     = 4,
   parameter int P     = 4,
   parameter int N     = 4,
   parameter int DW    = 16,
   parameter int M_LAT = 6,
   parameter int A_LAT = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              h_zero,
   input  logic              d_en,
   input  logic [H*DW-1:0]   dt_flat,
   input  logic [H*DW-1:0]   dA_flat,
   input  logic [N*DW-1:0]   B_flat,
   input  logic [N*DW-1:0]   C_flat,
   input  logic [H*DW-1:0]   D_flat,
   input  logic [H*P*DW-1:0] x_flat,
   input  logic [H*P*N*DW-1:0] h_prev_flat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [H*P*DW-1:0] y_flat,
   output logic [H*P*N*DW-1:0] h_next_flat,
   output logic              busy
);

   state_e state, state_n;
   phase_e ph;

   logic [H*DW-1:0]     dt_q, da_q, d_q;
   logic [N*DW-1:0]     b_q, c_q;
   logic [H*P*DW-1:0]   x_q;
   logic [H*P*N*DW-1:0] hp_q;
   logic                hz_q, de_q;

   logic [7:0]  h_i, p_i, n_i;
   logic [1:0]  sub;
   logic [15:0] cnt, lat;
   logic        accept, work, cap, row_end, row_last;
   logic [DW-1:0] dt_s, da_s, x_s, b_s, c_s, d_s, hp_s, sum;
   int          hi, ri, ei, ni;

   assign in_ready = (state == S_IDLE);
   assign busy     = ~in_ready;
   assign accept   = in_valid & in_ready;
   assign work     = state inside {S_DTX, S_ELEM, S_RES};
   assign row_last = (h_i == 8'(H - 1)) && (p_i == 8'(P - 1));

   always_comb begin
      unique case (1'b1)
         state == S_ELEM && sub == 2'd0: ph = PH_M1;
         state == S_ELEM && sub == 2'd1: ph = PH_A1;
         state == S_ELEM && sub == 2'd2: ph = PH_M2;
         state == S_ELEM && sub == 2'd3: ph = PH_A2;
         state == S_RES  && sub == 2'd0: ph = PH_RM;
         state == S_RES  && sub == 2'd1: ph = PH_RA;
         default:                        ph = PH_DTX;
      endcase
      lat     = is_mul(ph) ? 16'(M_LAT) : 16'(A_LAT);
      cap     = work && (cnt == lat - 16'd1);
      row_end = cap && ((ph == PH_A2 && n_i == 8'(N - 1) && !de_q)
                        || ph == PH_RA);
      hi   = int'(h_i);
      ni   = int'(n_i);
      ri   = hi * P + int'(p_i);
      ei   = ri * N + ni;
      dt_s = dt_q[hi*DW +: DW];
      da_s = da_q[hi*DW +: DW];
      d_s  = d_q[hi*DW +: DW];
      x_s  = x_q[ri*DW +: DW];
      b_s  = b_q[ni*DW +: DW];
      c_s  = c_q[ni*DW +: DW];
      hp_s = hp_q[ei*DW +: DW];
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: if (in_valid) state_n = S_DTX;
         S_DTX:  if (cap) state_n = S_ELEM;
         S_ELEM:
            if (cap && sub == 2'd3 && n_i == 8'(N - 1))
               state_n = de_q ? S_RES : (row_last ? S_OUT : S_DTX);
         S_RES:
            if (cap && sub == 2'd1)
               state_n = row_last ? S_OUT : S_DTX;
         default: if (out_valid && out_ready) state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   ssm_row_fp16 #(.DW(DW), .M_LAT(M_LAT), .A_LAT(A_LAT)) u_row (
      .clk(clk), .rst(rst), .ph(ph), .cap(cap), .h_zero(hz_q),
      .dt(dt_s), .da(da_s), .x(x_s), .b(b_s), .c(c_s), .d(d_s),
      .hp(hp_s), .sum(sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         {dt_q, da_q, d_q, b_q, c_q, x_q, hp_q} <= '0;
         hz_q        <= 1'b0;
         de_q        <= 1'b0;
         {h_i, p_i, n_i} <= '0;
         sub         <= '0;
         cnt         <= '0;
         y_flat      <= '0;
         h_next_flat <= '0;
         out_valid   <= 1'b0;
      end else begin
         if (accept) begin
            dt_q <= dt_flat;
            da_q <= dA_flat;
            d_q  <= D_flat;
            b_q  <= B_flat;
            c_q  <= C_flat;
            x_q  <= x_flat;
            hp_q <= h_prev_flat;
            hz_q <= h_zero;
            de_q <= d_en;
            {h_i, p_i, n_i} <= '0;
            sub  <= '0;
            cnt  <= '0;
         end else if (cap) begin
            cnt <= '0;
            if (state == S_ELEM) begin
               sub <= sub + 2'd1;
               if (sub == 2'd3)
                  n_i <= (n_i == 8'(N - 1)) ? 8'd0 : n_i + 8'd1;
            end
            if (state == S_RES) sub <= {1'b0, ~sub[0]};
            if (ph == PH_A1) h_next_flat[ei*DW +: DW] <= sum;
            if (row_end) begin
               y_flat[ri*DW +: DW] <= sum;
               if (p_i == 8'(P - 1)) begin
                  p_i <= 8'd0;
                  h_i <= h_i + 8'd1;
               end else begin
                  p_i <= p_i + 8'd1;
               end
            end
         end else if (work) begin
            cnt <= cnt + 16'd1;
         end
         // results are registered one cycle after the last row completes
         if (out_valid && out_ready) out_valid <= 1'b0;
         else if (state == S_OUT)    out_valid <= 1'b1;
      end
   end

endmodule
